block_sync_multilane: RTL
=========================

# block_sync_multilane

Parametrised multi-lane 64b/66b block synchroniser for the 100GbE PCS receive path. It sits between the PCS lane deserialiser and alignment-marker lock/deskew. Each lane searches for sync-header alignment by bit slipping, then declares and monitors block lock. Beyond the per-lane lock it adds a per-lane enable mask, a registered all-lanes-locked flag, per-lane lock-loss counters and a registered, aligned datapath.

## Interface
- NB_DATA, 66, coded block width per lane
- N_LANES, 20, number of PCS lanes
- MAX_WINDOW, 4096, largest programmable sh window
- NB_WINDOW_CNT, $clog2(MAX_WINDOW), window counter/limit width
- NB_INVALID_CNT, $clog2(MAX_WINDOW/2), invalid-sh counter/limit width
- NB_INDEX, $clog2(NB_DATA), slip index width
- NB_LOSS_CNT, 8, per-lane lock-loss counter width
- i_clock  in  1  single clock; all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  global enable; low freezes all state, counters and output registers
- i_valid  in  1  input word qualifier, common to all lanes
- i_signal_ok  in  1  PMA signal indication; low forces all lanes unlocked
- i_lane_enable  in  N_LANES  per-lane enable; bit i maps to lane i
- i_rf_unlocked_timer_limit  in  NB_WINDOW_CNT  consecutive valid sh required to lock
- i_rf_locked_timer_limit  in  NB_WINDOW_CNT  monitoring window length while locked
- i_rf_sh_invalid_limit  in  NB_INVALID_CNT  invalid sh per window that drops lock
- i_rf_loss_cnt_clear  in  1  synchronous clear of all lock-loss counters
- i_data  in  N_LANES*NB_DATA  lane 0 in the MSBs; within a lane, sh in the two MSBs
- o_data  out  N_LANES*NB_DATA  aligned blocks, same packing
- o_valid  out  1  i_valid delayed to match o_data
- o_sh_bus  out  N_LANES  aligned sh of lane i is 01 or 10
- o_block_lock  out  N_LANES  per-lane block lock
- o_all_locked  out  1  every enabled lane locked
- o_lock_loss_cnt  out  N_LANES*NB_LOSS_CNT  saturating lock-loss count per lane, lane 0 in the MSBs

## Operation
- Per lane, on each i_valid cycle: register the previous word and form concat = {prev_word, i_data_lane}. The aligned word is concat[2*NB_DATA-1-index -: NB_DATA]. Index 0 therefore yields prev_word unchanged.
- sh_valid = aligned[NB_DATA-1] XOR aligned[NB_DATA-2].
- Lane FSM states: UNLOCKED, LOCKED, SLIP.
  - UNLOCKED: every valid cycle increments sh_cnt.
    - Invalid sh -> SLIP.
    - sh_cnt reaches max(unlocked_limit, 1) with no invalid -> LOCKED; block_lock set; counters cleared.
  - LOCKED: every valid cycle increments sh_cnt; invalid sh also increments invalid_cnt.
    - invalid_cnt reaches max(invalid_limit, 1) -> SLIP; block_lock cleared; loss counter incremented, saturating at all-ones.
    - Otherwise, sh_cnt reaches max(locked_limit, 1) -> counters cleared; state stays LOCKED.
    - Both on the same sample -> SLIP wins.
  - SLIP: lasts exactly one clock regardless of i_valid. index = (index == NB_DATA-1) ? 0 : index+1. Counters cleared. Next state UNLOCKED.
- Precedence, highest first:
  1. i_reset
  2. i_enable low (hold everything)
  3. i_signal_ok low or lane disabled (state UNLOCKED, index 0, counters 0, block_lock 0; loss counter held)
  4. i_rf_loss_cnt_clear (clears loss counters, FSM otherwise runs normally)
  5. normal FSM
- A lock lost through signal_ok or lane disable does not count as a lock loss.
- o_all_locked = AND over enabled lanes of block_lock, registered. It is 0 when no lane is enabled.

## Timing
- Reset values: o_data 0, o_valid 0, o_sh_bus 0, o_block_lock 0, o_all_locked 0, o_lock_loss_cnt 0. Per lane: index 0, state UNLOCKED, prev_word 0.
- o_data and o_sh_bus are registered. They update one clock after an i_valid cycle and hold otherwise. o_valid is i_valid delayed 1 clock.
- o_block_lock asserts 1 clock after the sample that completes the unlocked window, and deasserts 1 clock after the sample that hits the invalid limit.
- o_all_locked lags o_block_lock by 1 clock.
- Limit changes take effect at the next comparison. A limit at or below the current count triggers on the next valid sample.
- The slip cycle discards no data, but the next aligned word straddles the old and new index. That word is checked as a normal sample.

## Structure
- Package block_sync_pkg holds:
  - lane FSM state localparams
  - a sh_is_valid function
  - lane-slice helper macros or functions for MSB-first packing
- Sub-module block_sync_lane holds one lane: slip buffer, index, FSM, counters, loss counter. The top instantiates it N_LANES times in a generate loop and adds only the enable mask, the all-locked reduction and the o_valid register.

## Test plan
- Clean lane data aligned at index 0, sh alternating 01/10, unlocked limit 64 -> block_lock rises 65 clocks after the first valid word; loss_cnt 0; o_data equals input delayed 1 word.
- Lane 2 stream rotated so alignment is at index 5 -> exactly 5 SLIP cycles, then lock; index 5; o_data reproduces the original blocks.
- Locked, window 1024, invalid limit 65, inject 65 invalid sh in one window -> block_lock drops the clock after the 65th; loss_cnt 1; o_all_locked 0 one clock later.
- Locked, same limits, 64 invalid sh in one window, then 64 in the next -> lock held throughout; loss_cnt 0.
- i_signal_ok low for 1 clock while all lanes locked -> all o_block_lock 0 next clock; indices 0; loss_cnt unchanged; relock after 64+1 valid words.
- i_lane_enable with bit 3 low, lane 3 fed random data, others clean -> o_all_locked 1. Then pulse i_rf_loss_cnt_clear after one induced loss -> that lane's counter returns to 0.

Source files
------------

// File: rtl/block_sync_pkg.sv
// Shared types and helpers for the multi-lane 64b/66b block synchroniser.
// Holds the lane FSM state encoding, the sync-header check, and the
// MSB-first lane slicing helper used to unpack/pack the lane buses.
package block_sync_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_SLIP     = 2'd2
  } lane_state_t;

  // A 66b sync header is legal only as 01 or 10.
  function automatic logic sh_is_valid(input logic [1:0] sh);
    return sh[1] ^ sh[0];
  endfunction

  // LSB position of lane 'lane' in a bus where lane 0 occupies the MSBs.
  function automatic int lane_lsb(input int lane, input int width, input int n_lanes);
    return (n_lanes - 1 - lane) * width;
  endfunction

endpackage

// File: rtl/block_sync_lane.sv
// One lane of the block synchroniser: slip buffer, bit-slip index, lock FSM,
// sh/invalid window counters, saturating lock-loss counter, aligned output reg.
// Ports: i_clock/i_reset, global i_enable, i_valid, i_signal_ok, i_lane_enable,
//   rf limits and loss clear, i_data (sh in MSBs) -> o_data, o_sh_valid,
//   o_block_lock, o_loss_cnt.
module block_sync_lane
  import block_sync_pkg::*;
#(
  parameter int NB_DATA        = 66,
  parameter int NB_WINDOW_CNT  = 12,
  parameter int NB_INVALID_CNT = 11,
  parameter int NB_INDEX       = 7,
  parameter int NB_LOSS_CNT    = 8
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_valid,
  input  logic                      i_signal_ok,
  input  logic                      i_lane_enable,
  input  logic [NB_WINDOW_CNT-1:0]  i_rf_unlocked_timer_limit,
  input  logic [NB_WINDOW_CNT-1:0]  i_rf_locked_timer_limit,
  input  logic [NB_INVALID_CNT-1:0] i_rf_sh_invalid_limit,
  input  logic                      i_rf_loss_cnt_clear,
  input  logic [NB_DATA-1:0]        i_data,
  output logic [NB_DATA-1:0]        o_data,
  output logic                      o_sh_valid,
  output logic                      o_block_lock,
  output logic [NB_LOSS_CNT-1:0]    o_loss_cnt
);

  lane_state_t               state_q, state_d;
  logic [NB_DATA-1:0]        prev_word_q, prev_word_d;
  logic                      primed_q, primed_d;
  logic [NB_INDEX-1:0]       index_q, index_d;
  logic [NB_WINDOW_CNT-1:0]  sh_cnt_q, sh_cnt_d;
  logic [NB_INVALID_CNT-1:0] invalid_cnt_q, invalid_cnt_d;
  logic                      block_lock_q, block_lock_d;
  logic [NB_LOSS_CNT-1:0]    loss_cnt_q, loss_cnt_d;
  logic [NB_DATA-1:0]        data_q, data_d;
  logic                      sh_ok_q, sh_ok_d;

  logic [2*NB_DATA-1:0]      concat;
  logic [NB_INDEX:0]         sel_lsb;
  logic [NB_DATA-1:0]        aligned;
  logic                      sh_ok;
  logic                      sample;
  logic [NB_WINDOW_CNT:0]    sh_cnt_inc;
  logic [NB_INVALID_CNT:0]   invalid_cnt_inc;
  logic [NB_WINDOW_CNT-1:0]  unlocked_lim, locked_lim;
  logic [NB_INVALID_CNT-1:0] invalid_lim;
  logic                      unlock_hit, window_hit, invalid_hit;

  // Index k picks the window starting k bits into the previous word.
  assign concat  = {prev_word_q, i_data};
  assign sel_lsb = (NB_INDEX+1)'(NB_DATA) - {1'b0, index_q};
  assign aligned = concat[sel_lsb +: NB_DATA];
  assign sh_ok   = sh_is_valid(aligned[NB_DATA-1 -: 2]);

  // The first word after reset or a forced unlock only fills the slip buffer;
  // judging the zeroed buffer would cause a spurious slip.
  assign sample  = i_valid & primed_q;

  // A zero limit behaves as one; compare the incremented count so a limit at
  // or below the current count fires on the very next sample.
  assign unlocked_lim    = (i_rf_unlocked_timer_limit == '0) ? NB_WINDOW_CNT'(1) : i_rf_unlocked_timer_limit;
  assign locked_lim      = (i_rf_locked_timer_limit == '0) ? NB_WINDOW_CNT'(1) : i_rf_locked_timer_limit;
  assign invalid_lim     = (i_rf_sh_invalid_limit == '0) ? NB_INVALID_CNT'(1) : i_rf_sh_invalid_limit;
  assign sh_cnt_inc      = {1'b0, sh_cnt_q} + 1'b1;
  assign invalid_cnt_inc = {1'b0, invalid_cnt_q} + 1'b1;
  assign unlock_hit      = sh_cnt_inc >= {1'b0, unlocked_lim};
  assign window_hit      = sh_cnt_inc >= {1'b0, locked_lim};
  assign invalid_hit     = invalid_cnt_inc >= {1'b0, invalid_lim};

  always_comb begin
    state_d       = state_q;
    prev_word_d   = prev_word_q;
    primed_d      = primed_q;
    index_d       = index_q;
    sh_cnt_d      = sh_cnt_q;
    invalid_cnt_d = invalid_cnt_q;
    block_lock_d  = block_lock_q;
    loss_cnt_d    = loss_cnt_q;
    data_d        = data_q;
    sh_ok_d       = sh_ok_q;

    // Datapath keeps flowing in every state, including the slip cycle.
    if (i_valid) begin
      prev_word_d = i_data;
      primed_d    = 1'b1;
      data_d      = aligned;
      sh_ok_d     = sh_ok;
    end

    if (!i_signal_ok || !i_lane_enable) begin
      // Forced unlock: not a lock loss, so the loss counter is left alone.
      state_d       = ST_UNLOCKED;
      index_d       = '0;
      sh_cnt_d      = '0;
      invalid_cnt_d = '0;
      block_lock_d  = 1'b0;
      primed_d      = 1'b0;
    end else begin
      if (i_rf_loss_cnt_clear) begin
        loss_cnt_d = '0;
      end
      case (state_q)
        ST_SLIP: begin
          index_d       = (index_q == NB_INDEX'(NB_DATA-1)) ? '0 : index_q + 1'b1;
          sh_cnt_d      = '0;
          invalid_cnt_d = '0;
          state_d       = ST_UNLOCKED;
        end
        ST_LOCKED: begin
          if (sample) begin
            if (!sh_ok && invalid_hit) begin
              state_d      = ST_SLIP;
              block_lock_d = 1'b0;
              if (!i_rf_loss_cnt_clear && (loss_cnt_q != '1)) begin
                loss_cnt_d = loss_cnt_q + 1'b1;
              end
            end else if (window_hit) begin
              sh_cnt_d      = '0;
              invalid_cnt_d = '0;
            end else begin
              sh_cnt_d = sh_cnt_inc[NB_WINDOW_CNT-1:0];
              if (!sh_ok) begin
                invalid_cnt_d = invalid_cnt_inc[NB_INVALID_CNT-1:0];
              end
            end
          end
        end
        default: begin
          if (sample) begin
            if (!sh_ok) begin
              state_d  = ST_SLIP;
              sh_cnt_d = '0;
            end else if (unlock_hit) begin
              state_d       = ST_LOCKED;
              block_lock_d  = 1'b1;
              sh_cnt_d      = '0;
              invalid_cnt_d = '0;
            end else begin
              sh_cnt_d = sh_cnt_inc[NB_WINDOW_CNT-1:0];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= ST_UNLOCKED;
      prev_word_q   <= '0;
      primed_q      <= 1'b0;
      index_q       <= '0;
      sh_cnt_q      <= '0;
      invalid_cnt_q <= '0;
      block_lock_q  <= 1'b0;
      loss_cnt_q    <= '0;
      data_q        <= '0;
      sh_ok_q       <= 1'b0;
    end else if (i_enable) begin
      state_q       <= state_d;
      prev_word_q   <= prev_word_d;
      primed_q      <= primed_d;
      index_q       <= index_d;
      sh_cnt_q      <= sh_cnt_d;
      invalid_cnt_q <= invalid_cnt_d;
      block_lock_q  <= block_lock_d;
      loss_cnt_q    <= loss_cnt_d;
      data_q        <= data_d;
      sh_ok_q       <= sh_ok_d;
    end
  end

  assign o_data       = data_q;
  assign o_sh_valid   = sh_ok_q;
  assign o_block_lock = block_lock_q;
  assign o_loss_cnt   = loss_cnt_q;

endmodule

// File: rtl/block_sync_multilane.sv
// Multi-lane 64b/66b block synchroniser: N_LANES independent lanes plus the
// lane enable mask, registered all-locked flag and o_valid alignment register.
// Ports: per-lane buses packed lane 0 in MSBs (i_data, o_data, o_lock_loss_cnt);
//   o_sh_bus/o_block_lock/i_lane_enable bit i = lane i.
module block_sync_multilane
  import block_sync_pkg::*;
#(
  parameter int NB_DATA        = 66,
  parameter int N_LANES        = 20,
  parameter int MAX_WINDOW     = 4096,
  parameter int NB_WINDOW_CNT  = $clog2(MAX_WINDOW),
  parameter int NB_INVALID_CNT = $clog2(MAX_WINDOW/2),
  parameter int NB_INDEX       = $clog2(NB_DATA),
  parameter int NB_LOSS_CNT    = 8
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_enable,
  input  logic                           i_valid,
  input  logic                           i_signal_ok,
  input  logic [N_LANES-1:0]             i_lane_enable,
  input  logic [NB_WINDOW_CNT-1:0]       i_rf_unlocked_timer_limit,
  input  logic [NB_WINDOW_CNT-1:0]       i_rf_locked_timer_limit,
  input  logic [NB_INVALID_CNT-1:0]      i_rf_sh_invalid_limit,
  input  logic                           i_rf_loss_cnt_clear,
  input  logic [N_LANES*NB_DATA-1:0]     i_data,
  output logic [N_LANES*NB_DATA-1:0]     o_data,
  output logic                           o_valid,
  output logic [N_LANES-1:0]             o_sh_bus,
  output logic [N_LANES-1:0]             o_block_lock,
  output logic                           o_all_locked,
  output logic [N_LANES*NB_LOSS_CNT-1:0] o_lock_loss_cnt
);

  logic valid_q, valid_d;
  logic all_locked_q, all_locked_d;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    localparam int DLSB = lane_lsb(g, NB_DATA, N_LANES);
    localparam int LLSB = lane_lsb(g, NB_LOSS_CNT, N_LANES);

    block_sync_lane #(
      .NB_DATA        (NB_DATA),
      .NB_WINDOW_CNT  (NB_WINDOW_CNT),
      .NB_INVALID_CNT (NB_INVALID_CNT),
      .NB_INDEX       (NB_INDEX),
      .NB_LOSS_CNT    (NB_LOSS_CNT)
    ) u_lane (
      .i_clock                   (i_clock),
      .i_reset                   (i_reset),
      .i_enable                  (i_enable),
      .i_valid                   (i_valid),
      .i_signal_ok               (i_signal_ok),
      .i_lane_enable             (i_lane_enable[g]),
      .i_rf_unlocked_timer_limit (i_rf_unlocked_timer_limit),
      .i_rf_locked_timer_limit   (i_rf_locked_timer_limit),
      .i_rf_sh_invalid_limit     (i_rf_sh_invalid_limit),
      .i_rf_loss_cnt_clear       (i_rf_loss_cnt_clear),
      .i_data                    (i_data[DLSB +: NB_DATA]),
      .o_data                    (o_data[DLSB +: NB_DATA]),
      .o_sh_valid                (o_sh_bus[g]),
      .o_block_lock              (o_block_lock[g]),
      .o_loss_cnt                (o_lock_loss_cnt[LLSB +: NB_LOSS_CNT])
    );
  end

  // Disabled lanes are ignored; with no lane enabled the flag stays low.
  always_comb begin
    valid_d      = i_valid;
    all_locked_d = (|i_lane_enable) & (&(o_block_lock | ~i_lane_enable));
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      valid_q      <= 1'b0;
      all_locked_q <= 1'b0;
    end else if (i_enable) begin
      valid_q      <= valid_d;
      all_locked_q <= all_locked_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_all_locked = all_locked_q;

endmodule
